// File: rtl/cfgext_request_master.sv
// cfgext_request_master: takes decoded CfgRd0/CfgWr0 requests, issues one
// cfg_ext strobe to the config shadow, waits for read data with a timeout,
// and returns one completion descriptor per request over valid/ready.
module cfgext_request_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_write,
    input  logic [9:0]               req_register_number,
    input  logic [3:0]               req_function_number,
    input  logic [31:0]              req_write_data,
    input  logic [3:0]               req_byte_enable,
    input  logic [7:0]               req_tag,
    input  logic [15:0]              req_requester_id,
    output logic                     cfg_ext_read_received,
    output logic                     cfg_ext_write_received,
    output logic [9:0]               cfg_ext_register_number,
    output logic [3:0]               cfg_ext_function_number,
    output logic [31:0]              cfg_ext_write_data,
    output logic [3:0]               cfg_ext_write_byte_enable,
    input  logic [31:0]              cfg_ext_read_data,
    input  logic                     cfg_ext_read_data_valid,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic                     cpl_has_data,
    output logic [2:0]               cpl_status,
    output logic [31:0]              cpl_data,
    output logic [7:0]               cpl_tag,
    output logic [15:0]              cpl_requester_id,
    output logic [6:0]               cpl_lower_addr,
    output logic [TIMEOUT_CNT_W-1:0] timeout_count
);

    localparam int unsigned TMR_W     = 8;
    localparam logic [2:0]  ST_SC     = 3'b000;
    localparam logic [2:0]  ST_UR     = 3'b001;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2,
        S_CPL     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_is_write;
    logic [TMR_W-1:0]  r_timer;

    logic              w_accept;
    logic              w_bad_func;
    logic              w_rd_ok;
    logic              w_timeout;
    logic              w_cpl_enter;
    logic              w_has_data;
    logic [2:0]        w_status;
    logic [31:0]       w_cpl_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    w_next = (req_function_number != 4'h0) ? S_CPL : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = r_is_write ? S_CPL : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (cfg_ext_read_data_valid || (r_timer == TMR_LAST)) begin
                    w_next = S_CPL;
                end
            end
            S_CPL: begin
                if (cpl_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered completion fields
    always_comb begin
        w_accept    = (r_state == S_IDLE) && req_valid && req_ready;
        w_bad_func  = w_accept && (req_function_number != 4'h0);
        w_rd_ok     = (r_state == S_WAIT_RD) && cfg_ext_read_data_valid;
        w_timeout   = (r_state == S_WAIT_RD) && !cfg_ext_read_data_valid
                      && (r_timer == TMR_LAST);
        w_cpl_enter = (w_next == S_CPL) && (r_state != S_CPL);
        w_has_data  = w_rd_ok;
        w_status    = (w_bad_func || w_timeout) ? ST_UR : ST_SC;
        w_cpl_data  = w_rd_ok ? cfg_ext_read_data : 32'h0;
    end

    // Registered outputs, captured request and read timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready                 <= 1'b1;
            r_is_write                <= 1'b0;
            r_timer                   <= '0;
            cfg_ext_read_received     <= 1'b0;
            cfg_ext_write_received    <= 1'b0;
            cfg_ext_register_number   <= '0;
            cfg_ext_function_number   <= '0;
            cfg_ext_write_data        <= '0;
            cfg_ext_write_byte_enable <= '0;
            cpl_valid                 <= 1'b0;
            cpl_has_data              <= 1'b0;
            cpl_status                <= '0;
            cpl_data                  <= '0;
            cpl_tag                   <= '0;
            cpl_requester_id          <= '0;
            cpl_lower_addr            <= '0;
            timeout_count             <= '0;
        end else begin
            req_ready              <= (w_next == S_IDLE);
            cpl_valid              <= (w_next == S_CPL);
            cfg_ext_read_received  <= w_accept && !w_bad_func && !req_is_write;
            cfg_ext_write_received <= w_accept && !w_bad_func && req_is_write;

            if (w_accept) begin
                r_is_write       <= req_is_write;
                cpl_tag          <= req_tag;
                cpl_requester_id <= req_requester_id;
                cpl_lower_addr   <= {req_register_number[4:0], 2'b00};
                if (!w_bad_func) begin
                    cfg_ext_register_number   <= req_register_number;
                    cfg_ext_function_number   <= req_function_number;
                    cfg_ext_write_data        <= req_write_data;
                    cfg_ext_write_byte_enable <= req_byte_enable;
                end
            end

            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT_RD) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_cpl_enter) begin
                cpl_has_data <= w_has_data;
                cpl_status   <= w_status;
                cpl_data     <= w_cpl_data;
            end

            if (w_timeout && (timeout_count != '1)) begin
                timeout_count <= timeout_count + TIMEOUT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cfgext_request_master.sv
// Directed bench for cfgext_request_master (TIMEOUT_CYCLES = 16).
module tb_cfgext_request_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_write;
    logic [9:0]  req_register_number;
    logic [3:0]  req_function_number;
    logic [31:0] req_write_data;
    logic [3:0]  req_byte_enable;
    logic [7:0]  req_tag;
    logic [15:0] req_requester_id;
    logic        cfg_ext_read_received;
    logic        cfg_ext_write_received;
    logic [9:0]  cfg_ext_register_number;
    logic [3:0]  cfg_ext_function_number;
    logic [31:0] cfg_ext_write_data;
    logic [3:0]  cfg_ext_write_byte_enable;
    logic [31:0] cfg_ext_read_data;
    logic        cfg_ext_read_data_valid;
    logic        cpl_valid;
    logic        cpl_ready;
    logic        cpl_has_data;
    logic [2:0]  cpl_status;
    logic [31:0] cpl_data;
    logic [7:0]  cpl_tag;
    logic [15:0] cpl_requester_id;
    logic [6:0]  cpl_lower_addr;
    logic [15:0] timeout_count;

    int n_checks = 0;
    int n_errors = 0;

    cfgext_request_master #(
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_CNT_W  (16)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_is_write              (req_is_write),
        .req_register_number       (req_register_number),
        .req_function_number       (req_function_number),
        .req_write_data            (req_write_data),
        .req_byte_enable           (req_byte_enable),
        .req_tag                   (req_tag),
        .req_requester_id          (req_requester_id),
        .cfg_ext_read_received     (cfg_ext_read_received),
        .cfg_ext_write_received    (cfg_ext_write_received),
        .cfg_ext_register_number   (cfg_ext_register_number),
        .cfg_ext_function_number   (cfg_ext_function_number),
        .cfg_ext_write_data        (cfg_ext_write_data),
        .cfg_ext_write_byte_enable (cfg_ext_write_byte_enable),
        .cfg_ext_read_data         (cfg_ext_read_data),
        .cfg_ext_read_data_valid   (cfg_ext_read_data_valid),
        .cpl_valid                 (cpl_valid),
        .cpl_ready                 (cpl_ready),
        .cpl_has_data              (cpl_has_data),
        .cpl_status                (cpl_status),
        .cpl_data                  (cpl_data),
        .cpl_tag                   (cpl_tag),
        .cpl_requester_id          (cpl_requester_id),
        .cpl_lower_addr            (cpl_lower_addr),
        .timeout_count             (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge: the next cycle's view
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in cycle 1
    task automatic send(input logic wr, input logic [9:0] rn, input logic [3:0] fn,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [7:0] tg, input logic [15:0] rid);
        req_is_write        = wr;
        req_register_number = rn;
        req_function_number = fn;
        req_write_data      = wd;
        req_byte_enable     = be;
        req_tag             = tg;
        req_requester_id    = rid;
        req_valid           = 1'b1;
        step();
        req_valid           = 1'b0;
    endtask

    // Run a read with no valid; returns in the first cpl_valid cycle
    task automatic read_timeout(input logic [7:0] tg, output int n);
        send(1'b0, 10'h003, 4'h0, 32'h0, 4'hF, tg, 16'h0102);
        chk("to_rd_strobe", 64'(cfg_ext_read_received), 64'd1);
        n = 1;
        while (!cpl_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_is_write = 1'b0; req_register_number = '0;
        req_function_number = '0; req_write_data = '0; req_byte_enable = '0;
        req_tag = '0; req_requester_id = '0;
        cfg_ext_read_data = '0; cfg_ext_read_data_valid = 1'b0;
        cpl_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("rst_rd_strobe", 64'(cfg_ext_read_received), 64'd0);
        chk("rst_wr_strobe", 64'(cfg_ext_write_received), 64'd0);
        chk("rst_tocnt", 64'(timeout_count), 64'd0);

        // Write: strobe at cycle 1, completion at cycle 2
        send(1'b1, 10'h001, 4'h0, 32'h8765_4321, 4'hF, 8'h11, 16'hABCD);
        chk("wr_strobe", 64'(cfg_ext_write_received), 64'd1);
        chk("wr_no_rd_strobe", 64'(cfg_ext_read_received), 64'd0);
        chk("wr_reg", 64'(cfg_ext_register_number), 64'h001);
        chk("wr_func", 64'(cfg_ext_function_number), 64'h0);
        chk("wr_data", 64'(cfg_ext_write_data), 64'h8765_4321);
        chk("wr_be", 64'(cfg_ext_write_byte_enable), 64'hF);
        chk("wr_req_ready_c1", 64'(req_ready), 64'd0);
        chk("wr_cpl_valid_c1", 64'(cpl_valid), 64'd0);
        step();
        chk("wr_strobe_c2", 64'(cfg_ext_write_received), 64'd0);
        chk("wr_data_hold", 64'(cfg_ext_write_data), 64'h8765_4321);
        chk("wr_cpl_valid", 64'(cpl_valid), 64'd1);
        chk("wr_has_data", 64'(cpl_has_data), 64'd0);
        chk("wr_status", 64'(cpl_status), 64'd0);
        chk("wr_lower_addr", 64'(cpl_lower_addr), 64'h04);
        chk("wr_tag", 64'(cpl_tag), 64'h11);
        chk("wr_rid", 64'(cpl_requester_id), 64'hABCD);
        step();
        chk("wr_cpl_drop", 64'(cpl_valid), 64'd0);
        chk("wr_req_ready_back", 64'(req_ready), 64'd1);

        // Read with valid at cycle 2 -> cpl_valid at cycle 3
        send(1'b0, 10'h001, 4'h0, 32'h0, 4'hF, 8'h22, 16'h1234);
        chk("rd_strobe", 64'(cfg_ext_read_received), 64'd1);
        chk("rd_no_wr_strobe", 64'(cfg_ext_write_received), 64'd0);
        step();
        cfg_ext_read_data = 32'h1234_5678;
        cfg_ext_read_data_valid = 1'b1;
        chk("rd_strobe_c2", 64'(cfg_ext_read_received), 64'd0);
        chk("rd_cpl_valid_c2", 64'(cpl_valid), 64'd0);
        step();
        cfg_ext_read_data_valid = 1'b0;
        cfg_ext_read_data = 32'hFFFF_FFFF;
        chk("rd_cpl_valid_c3", 64'(cpl_valid), 64'd1);
        chk("rd_has_data", 64'(cpl_has_data), 64'd1);
        chk("rd_status", 64'(cpl_status), 64'd0);
        chk("rd_data", 64'(cpl_data), 64'h1234_5678);
        chk("rd_lower_addr", 64'(cpl_lower_addr), 64'h04);
        chk("rd_tag", 64'(cpl_tag), 64'h22);
        step();

        // Timeout reads: 16 WAIT_RD cycles (2..17), cpl at cycle 18
        read_timeout(8'h33, n);
        chk("to1_latency", 64'(n), 64'd18);
        chk("to1_status", 64'(cpl_status), 64'd1);
        chk("to1_has_data", 64'(cpl_has_data), 64'd0);
        chk("to1_data", 64'(cpl_data), 64'd0);
        chk("to1_lower_addr", 64'(cpl_lower_addr), 64'h0C);
        chk("to1_tag", 64'(cpl_tag), 64'h33);
        chk("to1_tocnt", 64'(timeout_count), 64'd1);
        step();
        read_timeout(8'h34, n);
        chk("to2_latency", 64'(n), 64'd18);
        chk("to2_status", 64'(cpl_status), 64'd1);
        chk("to2_tocnt", 64'(timeout_count), 64'd2);
        step();

        // Valid on the final WAIT_RD cycle (cycle 17) wins
        send(1'b0, 10'h003, 4'h0, 32'h0, 4'hF, 8'h35, 16'h0102);
        for (int i = 0; i < 16; i++) step();
        chk("last_no_cpl_yet", 64'(cpl_valid), 64'd0);
        cfg_ext_read_data = 32'hCAFE_F00D;
        cfg_ext_read_data_valid = 1'b1;
        step();
        cfg_ext_read_data_valid = 1'b0;
        chk("last_cpl_valid", 64'(cpl_valid), 64'd1);
        chk("last_status", 64'(cpl_status), 64'd0);
        chk("last_has_data", 64'(cpl_has_data), 64'd1);
        chk("last_data", 64'(cpl_data), 64'hCAFE_F00D);
        chk("last_tocnt", 64'(timeout_count), 64'd2);
        step();

        // Non-zero function: UR at cycle 1, no strobe
        send(1'b0, 10'h005, 4'h1, 32'h0, 4'hF, 8'h44, 16'h5555);
        chk("fn_cpl_valid", 64'(cpl_valid), 64'd1);
        chk("fn_status", 64'(cpl_status), 64'd1);
        chk("fn_has_data", 64'(cpl_has_data), 64'd0);
        chk("fn_data", 64'(cpl_data), 64'd0);
        chk("fn_rd_strobe", 64'(cfg_ext_read_received), 64'd0);
        chk("fn_wr_strobe", 64'(cfg_ext_write_received), 64'd0);
        chk("fn_lower_addr", 64'(cpl_lower_addr), 64'h14);
        chk("fn_tag", 64'(cpl_tag), 64'h44);
        chk("fn_rid", 64'(cpl_requester_id), 64'h5555);
        step();
        chk("fn_cpl_drop", 64'(cpl_valid), 64'd0);

        // Stray read-data valid while idle is ignored
        cfg_ext_read_data = 32'hDEAD_BEEF;
        cfg_ext_read_data_valid = 1'b1;
        step();
        cfg_ext_read_data_valid = 1'b0;
        step();
        chk("stray_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("stray_req_ready", 64'(req_ready), 64'd1);
        chk("stray_tocnt", 64'(timeout_count), 64'd2);

        // Back-pressure: cpl held 5 cycles, new request not accepted
        cpl_ready = 1'b0;
        send(1'b0, 10'h002, 4'h0, 32'h0, 4'hF, 8'h55, 16'h7777);
        step();
        cfg_ext_read_data = 32'h0BAD_BEEF;
        cfg_ext_read_data_valid = 1'b1;
        step();
        cfg_ext_read_data_valid = 1'b0;
        cfg_ext_read_data = 32'h0;
        req_is_write = 1'b1; req_register_number = 10'h00A; req_function_number = 4'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cpl_valid", 64'(cpl_valid), 64'd1);
            chk("bp_data", 64'(cpl_data), 64'h0BAD_BEEF);
            chk("bp_has_data", 64'(cpl_has_data), 64'd1);
            chk("bp_status", 64'(cpl_status), 64'd0);
            chk("bp_tag", 64'(cpl_tag), 64'h55);
            chk("bp_rid", 64'(cpl_requester_id), 64'h7777);
            chk("bp_lower_addr", 64'(cpl_lower_addr), 64'h08);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_wr_strobe", 64'(cfg_ext_write_received), 64'd0);
            step();
        end
        req_valid = 1'b0;
        cpl_ready = 1'b1;
        step();
        chk("bp_cpl_drop", 64'(cpl_valid), 64'd0);
        chk("bp_req_ready_back", 64'(req_ready), 64'd1);
        step();
        chk("bp_no_late_wr", 64'(cfg_ext_write_received), 64'd0);
        chk("bp_reg_unchanged", 64'(cfg_ext_register_number), 64'h002);

        // Reset asserted during WAIT_RD
        send(1'b0, 10'h007, 4'h0, 32'h0, 4'hF, 8'h66, 16'h8888);
        step();
        rst = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'd1);
        chk("arst_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("arst_tocnt", 64'(timeout_count), 64'd0);
        chk("arst_reg", 64'(cfg_ext_register_number), 64'd0);
        chk("arst_tag", 64'(cpl_tag), 64'd0);
        step(); step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (cpl_valid || !req_ready) n++;
        end
        chk("arst_no_cpl", 64'(n), 64'd0);
        chk("arst_tocnt_after", 64'(timeout_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cfgext_request_master.md
Name: cfgext_request_master

Overview:
- Initiator side of the cfg_ext extended-configuration interface.
- Accepts decoded configuration requests (CfgRd0/CfgWr0 fields) from the RX TLP path.
- Issues single-cycle cfg_ext read/write strobes to the config-space shadow and waits for read data, with a timeout.
- Returns one completion descriptor per request to the TX completion builder over a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_RD before completing with UR; legal range 2..255.
TIMEOUT_CNT_W, 16, width of the saturating timeout statistics counter.

Ports:
clk  in  1  single system clock, all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_is_write  in  1  1 = CfgWr, 0 = CfgRd.
req_register_number  in  10  DWORD register index.
req_function_number  in  4  target function.
req_write_data  in  32  write payload.
req_byte_enable  in  4  first-DW byte enables.
req_tag  in  8  request tag, echoed in completion.
req_requester_id  in  16  requester ID, echoed in completion.
cfg_ext_read_received  out  1  one-cycle read strobe.
cfg_ext_write_received  out  1  one-cycle write strobe.
cfg_ext_register_number  out  10  register index for strobe.
cfg_ext_function_number  out  4  function for strobe.
cfg_ext_write_data  out  32  write data for strobe.
cfg_ext_write_byte_enable  out  4  byte enables for strobe.
cfg_ext_read_data  in  32  read data from shadow.
cfg_ext_read_data_valid  in  1  read data qualifier.
cpl_valid  out  1  completion descriptor valid.
cpl_ready  in  1  downstream accepts descriptor.
cpl_has_data  out  1  1 = CplD, 0 = Cpl.
cpl_status  out  3  3'b000 SC, 3'b001 UR.
cpl_data  out  32  read data (zero when cpl_has_data = 0).
cpl_tag  out  8  echoed tag.
cpl_requester_id  out  16  echoed requester ID.
cpl_lower_addr  out  7  {register_number[4:0], 2'b00}.
timeout_count  out  TIMEOUT_CNT_W  saturating count of read timeouts.

Behaviour:
- Reset (async assert, sync release): state = IDLE, all outputs 0 except req_ready = 1; timeout_count = 0; any captured request is dropped and no completion is emitted.
- All cfg_ext_* and cpl_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD, CPL.
- IDLE:
  - req_ready = 1; it is low in every other state.
  - On req_valid && req_ready, capture all req_* fields.
  - Function != 0: go to CPL with UR, cpl_has_data = 0; no cfg_ext strobe is issued.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert cfg_ext_read_received or cfg_ext_write_received with captured register, function, data and byte enables.
  - Address/data outputs hold their captured values after the strobe.
  - Write: go to CPL with SC, cpl_has_data = 0. Byte enable 4'h0 is still issued and still returns SC.
  - Read: clear timer, go to WAIT_RD.
- WAIT_RD:
  - cfg_ext_read_data_valid is sampled only in this state; valid in any other state is ignored.
  - On valid: latch cfg_ext_read_data into cpl_data, go to CPL with SC, cpl_has_data = 1.
  - Otherwise the timer increments. If timer == TIMEOUT_CYCLES-1 with no valid: go to CPL with UR, cpl_has_data = 0, cpl_data = 0, and timeout_count increments (saturating at all-ones).
  - Valid arriving on that final cycle wins: SC, no timeout is counted.
- CPL:
  - cpl_valid = 1; all cpl_* outputs are stable while cpl_valid && !cpl_ready.
  - On cpl_ready: cpl_valid drops next cycle and the FSM returns to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake.
- Latency from acceptance at cycle 0:
  - Strobe at cycle 1.
  - Write: cpl_valid at cycle 2.
  - Read with valid at cycle N (N >= 2): cpl_valid at cycle N+1.
  - Function != 0: cpl_valid at cycle 1.
- Throughput: one outstanding request at most; no pipelining.
- cpl_lower_addr and cpl_tag/cpl_requester_id derive from the captured request for every completion type, UR included.

Test Plan:
- Write reg 0x001, function 0, data 0x87654321, BE 0xF -> write strobe at cycle 1 with those values; cpl at cycle 2: has_data 0, status 000, lower_addr 0x04, tag echoed.
- Read reg 0x001 with shadow returning valid one cycle after the strobe, data 0x12345678 -> CplD, status 000, cpl_data 0x12345678, lower_addr 0x04, cpl_valid at cycle 3.
- Read with no valid ever (TIMEOUT_CYCLES = 16) -> exactly 16 WAIT_RD cycles, then Cpl with UR, cpl_data 0, timeout_count 0 -> 1; a second such read -> 2.
- Read with function 4'h1 -> no cfg_ext strobe, UR completion at cycle 1; stray valid pulse while IDLE -> no effect.
- Read completion with cpl_ready held low for 5 cycles -> cpl_valid and all cpl_* fields stable for 5 cycles, req_ready = 0, and a req_valid presented meanwhile is not accepted.
- Assert rst during WAIT_RD -> all outputs return to reset values immediately, no completion is produced, and req_ready = 1 after release.
